// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end: issues one memory request at a time and queues
// returned instructions in a 2-entry FIFO in front of decode.
module instr_fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_npc
);

    // state | meaning
    // IDLE  | no request outstanding
    // WAIT  | request outstanding, response will be queued
    // DROP  | request outstanding, response will be discarded (flushed)
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_nx;
    logic [31:0] req_addr;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_npc   [2];
    logic        push, pop, full;

    assign full       = (count == 2'(DEPTH));
    assign if_valid   = (count != 2'd0);
    assign pop        = if_valid && !stall && !flush;
    assign imem_req   = (state != IDLE);
    assign imem_addr  = req_addr;
    assign if_instr   = if_valid ? buf_instr[rd_ptr] : 32'h0;
    assign if_npc     = if_valid ? buf_npc[rd_ptr]   : 32'h0;

    always_comb begin
        state_nx   = state;
        pc_advance = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                // acks seen here belong to a request killed by reset; ignore them
                if (!full && !flush && !reset) begin
                    pc_advance = 1'b1;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    push     = !flush;
                    state_nx = IDLE;
                end else if (flush) begin
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= 32'h0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (pc_advance) req_addr <= pc;
            if (flush) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                if (push && !pop)      count <= count + 2'd1;
                else if (pop && !push) count <= count - 2'd1;
            end
        end
    end

    // Storage needs no reset: contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_npc[wr_ptr]   <= req_addr + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: basic fetch, back-pressure, flush in
// WAIT/DROP, flush with ack, push+pop, address wrap and mid-request reset.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_npc;

    int total = 0;
    int bad   = 0;

    instr_fetch_buffer #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_npc     (if_npc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs are then changed 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [31:0] I4  = 32'h0000_0444;
    localparam logic [31:0] I5  = 32'h0000_0555;
    localparam logic [31:0] I6  = 32'h0000_0666;
    localparam logic [31:0] I20 = 32'h0000_2020;
    localparam logic [31:0] I21 = 32'h0000_2121;
    localparam logic [31:0] I30 = 32'h0000_3030;
    localparam logic [31:0] I31 = 32'h0000_3131;
    localparam logic [31:0] IF  = 32'h0000_FFFF;

    initial begin
        reset = 1'b1; pc = 32'h0; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'h0; stall = 1'b0;
        cyc(); cyc();
        settle();
        chk("rst_pc_advance", {31'h0, pc_advance}, 32'h0);
        chk("rst_imem_req",   {31'h0, imem_req},   32'h0);
        chk("rst_imem_addr",  imem_addr,           32'h0);
        chk("rst_if_valid",   {31'h0, if_valid},   32'h0);
        chk("rst_if_instr",   if_instr,            32'h0);
        chk("rst_if_npc",     if_npc,              32'h0);

        // basic flow: issue pc=0, 1-cycle ack
        reset = 1'b0; settle();
        chk("basic_pc_advance", {31'h0, pc_advance}, 32'h1);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'hA000_0001; settle();
        chk("basic_imem_req",  {31'h0, imem_req},   32'h1);
        chk("basic_imem_addr", imem_addr,           32'h0);
        chk("basic_no_adv",    {31'h0, pc_advance}, 32'h0);
        chk("basic_not_valid", {31'h0, if_valid},   32'h0);
        cyc();
        imem_ack = 1'b0; pc = 32'd4; settle();
        chk("basic_valid", {31'h0, if_valid}, 32'h1);
        chk("basic_instr", if_instr,          32'hA000_0001);
        chk("basic_npc",   if_npc,            32'h1);
        cyc();

        // back-pressure: stall held while fetching 4,5,6
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = I4; settle();
        chk("bp_addr4", imem_addr, 32'd4);
        chk("bp_empty", {31'h0, if_valid}, 32'h0);
        cyc();
        imem_ack = 1'b0; pc = 32'd5; settle();
        chk("bp_adv5",  {31'h0, pc_advance}, 32'h1);
        chk("bp_head4", if_instr, I4);
        cyc();
        imem_ack = 1'b1; imem_rdata = I5; settle();
        chk("bp_addr5", imem_addr, 32'd5);
        cyc();
        imem_ack = 1'b0; pc = 32'd6; settle();
        chk("bp_full_no_adv", {31'h0, pc_advance}, 32'h0);
        chk("bp_head_stable", if_instr, I4);
        cyc();
        settle();
        chk("bp_still_no_adv", {31'h0, pc_advance}, 32'h0);
        chk("bp_no_req",       {31'h0, imem_req},   32'h0);
        stall = 1'b0; settle();
        chk("bp_out4_instr", if_instr, I4);
        chk("bp_out4_npc",   if_npc,   32'd5);
        cyc();
        settle();
        chk("bp_out5_instr", if_instr, I5);
        chk("bp_out5_npc",   if_npc,   32'd6);
        chk("bp_resume_adv", {31'h0, pc_advance}, 32'h1);
        cyc();
        imem_ack = 1'b1; imem_rdata = I6; settle();
        chk("bp_drained", {31'h0, if_valid}, 32'h0);
        chk("bp_addr6",   imem_addr,         32'd6);
        cyc();
        imem_ack = 1'b0; pc = 32'd8; settle();
        chk("bp_out6_npc", if_npc, 32'd7);
        cyc();

        // flush while WAIT with no ack -> DROP, ack discarded
        flush = 1'b1; settle();
        chk("fw_addr8",   imem_addr,           32'd8);
        chk("fw_no_adv",  {31'h0, pc_advance}, 32'h0);
        cyc();
        flush = 1'b0; pc = 32'd20; settle();
        chk("fw_drop_req",    {31'h0, imem_req},   32'h1);
        chk("fw_drop_no_adv", {31'h0, pc_advance}, 32'h0);
        chk("fw_drop_empty",  {31'h0, if_valid},   32'h0);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
        chk("fw_ack_no_adv", {31'h0, pc_advance}, 32'h0);
        cyc();
        imem_ack = 1'b0; settle();
        chk("fw_discarded", {31'h0, if_valid},   32'h0);
        chk("fw_idle",      {31'h0, imem_req},   32'h0);
        chk("fw_adv20",     {31'h0, pc_advance}, 32'h1);
        cyc();
        imem_ack = 1'b1; imem_rdata = I20; stall = 1'b1; settle();
        chk("fw_addr20", imem_addr, 32'd20);
        cyc();

        // flush coincident with ack, buffer holding one entry
        imem_ack = 1'b0; pc = 32'd21; settle();
        chk("fa_head20", if_instr, I20);
        chk("fa_npc21",  if_npc,   32'd21);
        cyc();
        flush = 1'b1; imem_ack = 1'b1; imem_rdata = I21; settle();
        chk("fa_no_adv", {31'h0, pc_advance}, 32'h0);
        cyc();
        flush = 1'b0; imem_ack = 1'b0; stall = 1'b0; pc = 32'd30; settle();
        chk("fa_cleared", {31'h0, if_valid}, 32'h0);
        chk("fa_instr0",  if_instr,          32'h0);
        chk("fa_idle",    {31'h0, imem_req}, 32'h0);
        chk("fa_adv",     {31'h0, pc_advance}, 32'h1);
        cyc();

        // simultaneous push and pop with count=1
        imem_ack = 1'b1; imem_rdata = I30; settle();
        cyc();
        imem_ack = 1'b0; pc = 32'd31; stall = 1'b1; settle();
        chk("pp_head30", if_instr, I30);
        cyc();
        imem_ack = 1'b1; imem_rdata = I31; stall = 1'b0; settle();
        chk("pp_pre_pop", if_instr, I30);
        cyc();
        imem_ack = 1'b0; stall = 1'b1; pc = 32'hFFFF_FFFF; settle();
        chk("pp_head31", if_instr, I31);
        chk("pp_npc32",  if_npc,   32'd32);
        chk("pp_adv",    {31'h0, pc_advance}, 32'h1);
        cyc();

        // wrap of fetch address
        stall = 1'b0; imem_ack = 1'b1; imem_rdata = IF; settle();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFF);
        cyc();
        imem_ack = 1'b0; pc = 32'd40; settle();
        chk("wr_instr", if_instr, IF);
        chk("wr_npc0",  if_npc,   32'h0);
        cyc();
        settle();
        chk("wr_count_was_1", {31'h0, if_valid}, 32'h0);
        chk("wr_req40",       imem_addr,         32'd40);

        // reset while WAIT, late ack ignored
        reset = 1'b1;
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555; flush = 1'b1; stall = 1'b1; settle();
        chk("rw_pc_advance", {31'h0, pc_advance}, 32'h0);
        chk("rw_imem_req",   {31'h0, imem_req},   32'h0);
        chk("rw_imem_addr",  imem_addr,           32'h0);
        chk("rw_if_valid",   {31'h0, if_valid},   32'h0);
        chk("rw_if_instr",   if_instr,            32'h0);
        chk("rw_if_npc",     if_npc,              32'h0);
        cyc();
        reset = 1'b0; flush = 1'b0; stall = 1'b0; settle();
        chk("rw_idle_adv", {31'h0, pc_advance}, 32'h1);
        cyc();
        imem_ack = 1'b0; settle();
        chk("rw_ack_ignored", {31'h0, if_valid}, 32'h0);
        chk("rw_new_req",     {31'h0, imem_req}, 32'h1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
